uart_digit_buffer: RTL and testbench

//  Upstream feeder of the 4-digit seven-segment driver. Consumes ASCII bytes strobed
//  out of the UART receiver, keeps a 4-character scrolling display buffer, and drives
//  the four registered digitN_segments buses (active-low) that the driver multiplexes.

---
 rtl/uart_digit_buffer_pkg.sv | 70 +++++++
 rtl/uart_digit_buffer_if.sv | 31 +++
 rtl/uart_digit_buffer_hex_to_7seg.sv | 41 ++++
 rtl/uart_digit_buffer.sv | 132 +++++++++++++
 tb/tb_uart_digit_buffer.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/uart_digit_buffer_pkg.sv
// ============================================================================
// Module : uart_disp_pkg
// Brief  : Segment encodings, ASCII command codes and byte classifier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [7:0] ASC_BS         = 8'h08;
  localparam logic [7:0] ASC_DEL        = 8'h7F;
  localparam logic [7:0] ASC_ESC        = 8'h1B;
  localparam logic [7:0] ASC_SPACE      = 8'h20;
  localparam logic [7:0] ASC_UNDERSCORE = 8'h5F;
  localparam logic [7:0] ASC_BANG       = 8'h21;

  typedef struct packed {
    logic       blank;
    logic [3:0] nib;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{blank: 1'b1, nib: 4'h0};

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_HEX   = 3'd1,
    CMD_SPACE = 3'd2,
    CMD_BACK  = 3'd3,
    CMD_CLEAR = 3'd4,
    CMD_BLINK = 3'd5
  } cmd_e;

  function automatic cmd_e classify(input logic [7:0] c);
    if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
        (c >= 8'h61 && c <= 8'h66))
      return CMD_HEX;
    if (c == ASC_SPACE || c == ASC_UNDERSCORE) return CMD_SPACE;
    if (c == ASC_BS || c == ASC_DEL)           return CMD_BACK;
    if (c == ASC_ESC)                          return CMD_CLEAR;
    if (c == ASC_BANG)                         return CMD_BLINK;
    return CMD_NONE;
  endfunction

  // Letters share the low nibble 1..6 in both cases, so +9 maps them to A..F.
  function automatic logic [3:0] ascii_nib(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    return c[3:0] + 4'd9;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_digit_buffer_if.sv
// ============================================================================
// Module : uart_digit_buffer_if
// Brief  : Byte strobe input and segment/status outputs of the digit buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface uart_digit_buffer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] digit0_segments;
  logic [6:0] digit1_segments;
  logic [6:0] digit2_segments;
  logic [6:0] digit3_segments;
  logic       char_accept;
  logic       char_reject;

  modport master (
    output rx_data, rx_valid,
    input  digit0_segments, digit1_segments, digit2_segments, digit3_segments,
    input  char_accept, char_reject
  );

  modport slave (
    input  rx_data, rx_valid,
    output digit0_segments, digit1_segments, digit2_segments, digit3_segments,
    output char_accept, char_reject
  );
endinterface

`default_nettype wire

// File: rtl/uart_digit_buffer_hex_to_7seg.sv
// ============================================================================
// Module : hex_to_7seg
// Brief  : Nibble plus blank flag to active-low {g,f,e,d,c,b,a} segments.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hex_to_7seg
  import uart_disp_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    if (!digit.blank) begin
      case (digit.nib)
        4'h0: segments = SEG_0;
        4'h1: segments = SEG_1;
        4'h2: segments = SEG_2;
        4'h3: segments = SEG_3;
        4'h4: segments = SEG_4;
        4'h5: segments = SEG_5;
        4'h6: segments = SEG_6;
        4'h7: segments = SEG_7;
        4'h8: segments = SEG_8;
        4'h9: segments = SEG_9;
        4'hA: segments = SEG_A;
        4'hB: segments = SEG_B;
        4'hC: segments = SEG_C;
        4'hD: segments = SEG_D;
        4'hE: segments = SEG_E;
        default: segments = SEG_F;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_digit_buffer.sv
// ============================================================================
// Module : uart_digit_buffer
// Brief  : ASCII-driven 4-digit scrolling display buffer with blink mode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_digit_buffer
  import uart_disp_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  uart_digit_buffer_if.slave bus
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  digit_t           r_dig [4];
  logic             r_blink_en;
  logic             r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_seg [4];
  logic             r_accept;
  logic             r_reject;

  digit_t           w_dig_nxt [4];
  digit_t           w_show    [4];
  logic [6:0]       w_seg     [4];
  logic             w_blink_en_nxt;
  logic             w_phase_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_reject;
  cmd_e             w_cmd;

  assign w_cmd = bus.rx_valid ? classify(bus.rx_data) : CMD_NONE;

  // Blink advance first; a byte command then overrides the blink state where it applies.
  always_comb begin
    w_dig_nxt      = r_dig;
    w_blink_en_nxt = r_blink_en;
    w_phase_nxt    = r_phase;
    w_cnt_nxt      = r_cnt;
    w_accept       = 1'b0;
    w_reject       = 1'b0;

    if (r_blink_en) begin
      if (r_cnt == CNT_MAX) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end

    if (bus.rx_valid) begin
      w_accept = (w_cmd != CMD_NONE);
      w_reject = (w_cmd == CMD_NONE);
    end

    case (w_cmd)
      CMD_HEX, CMD_SPACE: begin
        w_dig_nxt[3] = r_dig[2];
        w_dig_nxt[2] = r_dig[1];
        w_dig_nxt[1] = r_dig[0];
        w_dig_nxt[0] = (w_cmd == CMD_HEX) ? digit_t'{blank: 1'b0, nib: ascii_nib(bus.rx_data)}
                                          : DIGIT_BLANK;
      end
      CMD_BACK: begin
        w_dig_nxt[0] = r_dig[1];
        w_dig_nxt[1] = r_dig[2];
        w_dig_nxt[2] = r_dig[3];
        w_dig_nxt[3] = DIGIT_BLANK;
      end
      CMD_CLEAR: begin
        for (int i = 0; i < 4; i++) w_dig_nxt[i] = DIGIT_BLANK;
        w_blink_en_nxt = 1'b0;
        w_phase_nxt    = 1'b0;
        w_cnt_nxt      = '0;
      end
      CMD_BLINK: begin
        w_blink_en_nxt = ~r_blink_en;
        w_phase_nxt    = 1'b0;
        w_cnt_nxt      = '0;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_seg
    assign w_show[gi] = '{blank: w_dig_nxt[gi].blank | w_phase_nxt, nib: w_dig_nxt[gi].nib};
    hex_to_7seg u_hex (
      .digit    (w_show[gi]),
      .segments (w_seg[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_dig[i] <= DIGIT_BLANK;
        r_seg[i] <= SEG_BLANK;
      end
      r_blink_en <= 1'b0;
      r_phase    <= 1'b0;
      r_cnt      <= '0;
      r_accept   <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_dig      <= w_dig_nxt;
      r_seg      <= w_seg;
      r_blink_en <= w_blink_en_nxt;
      r_phase    <= w_phase_nxt;
      r_cnt      <= w_cnt_nxt;
      r_accept   <= w_accept;
      r_reject   <= w_reject;
    end
  end

  assign bus.digit0_segments = r_seg[0];
  assign bus.digit1_segments = r_seg[1];
  assign bus.digit2_segments = r_seg[2];
  assign bus.digit3_segments = r_seg[3];
  assign bus.char_accept     = r_accept;
  assign bus.char_reject     = r_reject;

endmodule

`default_nettype wire

// File: tb/tb_uart_digit_buffer.sv
// ============================================================================
// Module : tb_uart_digit_buffer
// Brief  : Directed self-checking bench for uart_digit_buffer (BLINK_DIV=8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_digit_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  uart_digit_buffer_if bus ();

  uart_digit_buffer #(.BLINK_DIV(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_digits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    check({tag, ".d3"}, 32'(bus.digit3_segments), 32'(e3));
    check({tag, ".d2"}, 32'(bus.digit2_segments), 32'(e2));
    check({tag, ".d1"}, 32'(bus.digit1_segments), 32'(e1));
    check({tag, ".d0"}, 32'(bus.digit0_segments), 32'(e0));
  endtask

  // Called at a falling edge; returns at the next falling edge with the result visible.
  task automatic send(input logic [7:0] b, input logic acc);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("accept", 32'(bus.char_accept), 32'(acc));
    check("reject", 32'(bus.char_reject), 32'(!acc));
  endtask

  initial begin
    logic [7:0] burst [4];
    burst[0] = 8'h46; burst[1] = 8'h30; burst[2] = 8'h45; burst[3] = 8'h5F;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // 1: reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_digits("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("reset.accept", 32'(bus.char_accept), 32'd0);
    check("reset.reject", 32'(bus.char_reject), 32'd0);

    // 2: hex entry and scroll
    send(8'h31, 1'b1);
    chk_digits("one", 7'h7F, 7'h7F, 7'h7F, 7'h79);
    send(8'h32, 1'b1);
    send(8'h33, 1'b1);
    send(8'h34, 1'b1);
    chk_digits("1234", 7'h79, 7'h24, 7'h30, 7'h19);
    send(8'h61, 1'b1);
    chk_digits("234a", 7'h24, 7'h30, 7'h19, 7'h08);

    // 3: backspace and unknown byte
    send(8'h08, 1'b1);
    chk_digits("bs1", 7'h7F, 7'h24, 7'h30, 7'h19);
    send(8'h7F, 1'b1);
    chk_digits("bs2", 7'h7F, 7'h7F, 7'h24, 7'h30);
    send(8'h5A, 1'b0);
    chk_digits("rejZ", 7'h7F, 7'h7F, 7'h24, 7'h30);

    // 4: blink on; k counts clock edges since the enabling edge
    send(8'h21, 1'b1);
    check("blink.k0", 32'(bus.digit0_segments), 32'h30);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      check($sformatf("blink.d0.k%0d", k), 32'(bus.digit0_segments),
            (k >= 8 && k <= 15) ? 32'h7F : 32'h30);
      check($sformatf("blink.d1.k%0d", k), 32'(bus.digit1_segments),
            (k >= 8 && k <= 15) ? 32'h7F : 32'h24);
    end
    // '!' lands on the wrap edge: disable wins, phase stays 0
    send(8'h21, 1'b1);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("blinkoff.k%0d", k), 32'(bus.digit0_segments), 32'h30);
      @(negedge clk);
    end

    // 5: back-to-back strobes
    for (int i = 0; i < 4; i++) begin
      bus.rx_data  = burst[i];
      bus.rx_valid = 1'b1;
      @(negedge clk);
      check($sformatf("burst.accept%0d", i), 32'(bus.char_accept), 32'd1);
    end
    bus.rx_valid = 1'b0;
    chk_digits("burst", 7'h0E, 7'h40, 7'h06, 7'h7F);
    send(8'h21, 1'b1);
    repeat (9) @(negedge clk);
    check("blink.phase1", 32'(bus.digit3_segments), 32'h7F);
    send(8'h1B, 1'b1);
    chk_digits("esc", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    send(8'h38, 1'b1);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("esc.blinkoff.k%0d", k), 32'(bus.digit0_segments), 32'h00);
      @(negedge clk);
    end

    // 6: asynchronous reset mid-blink with a byte in flight
    send(8'h21, 1'b1);
    repeat (3) @(negedge clk);
    check("pre_rst.d0", 32'(bus.digit0_segments), 32'h00);
    bus.rx_data  = 8'h39;
    bus.rx_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_digits("async_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    chk_digits("rst_hold", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("rst.accept", 32'(bus.char_accept), 32'd0);
    send(8'h37, 1'b1);
    check("post_rst.d1", 32'(bus.digit1_segments), 32'h7F);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("post_rst.d0.k%0d", k), 32'(bus.digit0_segments), 32'h78);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
